bitfusion_mac_pe: RTL and testbench

//  Parametrised, pipelined Bit-Fusion processing element: successor to the 4-bit fused multiplier.

---
 rtl/bitfusion_mac_pe_if.sv | 31 +++
 rtl/bitfusion_mac_pe.sv | 128 ++++++++++++
 tb/tb_bitfusion_mac_pe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitfusion_mac_pe_if.sv
// Operand/psum bundle for the Bit-Fusion MAC processing element.
// The master drives beats and collects psums; the slave is the PE.
interface bitfusion_mac_pe_if #(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 24
);
    localparam int WW = $clog2(MAX_BITS) + 1;

    logic                in_valid;
    logic                in_last;
    logic [MAX_BITS-1:0] in;
    logic [MAX_BITS-1:0] weight;
    logic [WW-1:0]       in_width;
    logic [WW-1:0]       weight_width;
    logic                s_in;
    logic                s_weight;
    logic [ACC_W-1:0]    psum;
    logic                psum_valid;
    logic                ovf;
    logic                cfg_err;

    modport master (
        output in_valid, in_last, in, weight, in_width, weight_width, s_in, s_weight,
        input  psum, psum_valid, ovf, cfg_err
    );

    modport slave (
        input  in_valid, in_last, in, weight, in_width, weight_width, s_in, s_weight,
        output psum, psum_valid, ovf, cfg_err
    );
endinterface

// File: rtl/bitfusion_mac_pe.sv
// Bit-Fusion MAC processing element: splits packed operands into lanes
// according to the per-beat widths, forms the lane dot product, and
// accumulates it over a group of beats. Two register stages:
// S1 holds the beat sum, S2 accumulates and publishes the group psum.
module bitfusion_mac_pe #(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 24
) (
    input logic               clk,
    input logic               rst_n,
    bitfusion_mac_pe_if.slave bus
);
    localparam int WW = $clog2(MAX_BITS) + 1;
    localparam int PW = 2 * MAX_BITS + 1;

    // A width is usable when it is a nonzero power of two no larger than the bus.
    function automatic logic width_ok(input logic [WW-1:0] w);
        return (w != '0) && ((w & (w - WW'(1))) == '0) && (w <= WW'(MAX_BITS));
    endfunction

    logic                    cfg_ok;
    logic [WW-1:0]           lane_w;
    logic signed [PW-1:0]    beat_sum;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [PW-1:0]    s1_sum;
    logic                    cfg_err_q;

    logic signed [ACC_W-1:0] acc;
    logic                    grp_ovf;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    add_ovf;

    logic [ACC_W-1:0]        psum_q;
    logic                    psum_valid_q;
    logic                    ovf_q;

    // Lane split and dot product of the beat currently on the bus.
    always_comb begin
        logic [MAX_BITS-1:0]    slot_in, slot_wt;
        logic [MAX_BITS-1:0]    mask_in, mask_wt;
        logic [MAX_BITS-1:0]    top_in, top_wt;
        logic signed [MAX_BITS:0] e_in, e_wt;
        logic signed [PW-1:0]   prod;
        int                     lw;

        cfg_ok   = width_ok(bus.in_width) && width_ok(bus.weight_width);
        lane_w   = (bus.in_width > bus.weight_width) ? bus.in_width : bus.weight_width;
        lw       = int'(lane_w);
        mask_in  = ~({MAX_BITS{1'b1}} << bus.in_width);
        mask_wt  = ~({MAX_BITS{1'b1}} << bus.weight_width);
        top_in   = {{(MAX_BITS-1){1'b0}}, 1'b1} << (bus.in_width - WW'(1));
        top_wt   = {{(MAX_BITS-1){1'b0}}, 1'b1} << (bus.weight_width - WW'(1));
        slot_in  = '0;
        slot_wt  = '0;
        e_in     = '0;
        e_wt     = '0;
        prod     = '0;
        beat_sum = '0;
        for (int k = 0; k < MAX_BITS; k++) begin
            if (cfg_ok && ((k + 1) * lw <= MAX_BITS)) begin
                slot_in  = bus.in >> (k * lw);
                slot_wt  = bus.weight >> (k * lw);
                // Elements narrower than the lane only use the low bits of the slot.
                e_in     = (bus.s_in && ((slot_in & top_in) != '0))
                         ? {1'b1, slot_in | ~mask_in} : {1'b0, slot_in & mask_in};
                e_wt     = (bus.s_weight && ((slot_wt & top_wt) != '0))
                         ? {1'b1, slot_wt | ~mask_wt} : {1'b0, slot_wt & mask_wt};
                prod     = e_in * e_wt;
                beat_sum = beat_sum + prod;
            end
        end
    end

    // S1: capture the beat sum and its tags; an illegal width yields a zero sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            s1_valid  <= bus.in_valid;
            s1_last   <= bus.in_valid && bus.in_last;
            s1_sum    <= bus.in_valid ? beat_sum : '0;
            cfg_err_q <= bus.in_valid && !cfg_ok;
        end
    end

    // Accumulator add with signed-overflow detection on the wrapped result.
    always_comb begin
        sum_ext = ACC_W'(s1_sum);
        acc_nxt = acc + sum_ext;
        add_ovf = (acc[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_nxt[ACC_W-1] != acc[ACC_W-1]);
    end

    // S2: accumulate, and on the last beat publish psum and restart the group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            grp_ovf      <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            psum_valid_q <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    psum_q       <= acc_nxt;
                    ovf_q        <= grp_ovf || add_ovf;
                    psum_valid_q <= 1'b1;
                    acc          <= '0;
                    grp_ovf      <= 1'b0;
                end else begin
                    acc          <= acc_nxt;
                    grp_ovf      <= grp_ovf || add_ovf;
                end
            end
        end
    end

    assign bus.psum       = psum_q;
    assign bus.psum_valid = psum_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_bitfusion_mac_pe.sv
// Directed and randomised bench for bitfusion_mac_pe (MAX_BITS=8, ACC_W=24).
// Expected group results are queued when the last beat is driven and
// compared when psum_valid appears, including the cycle it appears on.
module tb_bitfusion_mac_pe;
    localparam int MAX_BITS = 8;
    localparam int ACC_W    = 24;

    typedef struct {
        logic [ACC_W-1:0] psum;
        bit               ovf;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   cfg_seen = 0;
    int   cfg_exp = 0;
    logic [ACC_W-1:0] obs_psum = '0;
    bit               obs_ovf = 1'b0;
    exp_t exp_q[$];
    longint gacc = 0;
    bit     govf = 1'b0;

    bitfusion_mac_pe_if #(.MAX_BITS(MAX_BITS), .ACC_W(ACC_W)) bus ();

    bitfusion_mac_pe #(.MAX_BITS(MAX_BITS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit legal_w(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

    function automatic longint model_beat(input int a, input int w, input int iw, input int ww,
                                          input bit si, input bit sw);
        int     l;
        longint s;
        s = 0;
        if (!legal_w(iw) || !legal_w(ww)) return 0;
        l = (iw > ww) ? iw : ww;
        for (int k = 0; (k + 1) * l <= MAX_BITS; k++) begin
            int ea, eb;
            ea = ((a >> (k * l)) & ((1 << l) - 1)) & ((1 << iw) - 1);
            eb = ((w >> (k * l)) & ((1 << l) - 1)) & ((1 << ww) - 1);
            if (si && ea >= (1 << (iw - 1))) ea -= (1 << iw);
            if (sw && eb >= (1 << (ww - 1))) eb -= (1 << ww);
            s += longint'(ea) * longint'(eb);
        end
        return s;
    endfunction

    task automatic beat(input int a, input int w, input int iw, input int ww,
                        input bit si, input bit sw, input bit last);
        longint t;
        exp_t   e;
        bus.in_valid     = 1'b1;
        bus.in_last      = last;
        bus.in           = 8'(a);
        bus.weight       = 8'(w);
        bus.in_width     = 4'(iw);
        bus.weight_width = 4'(ww);
        bus.s_in         = si;
        bus.s_weight     = sw;
        if (!legal_w(iw) || !legal_w(ww)) cfg_exp++;
        t = gacc + model_beat(a, w, iw, ww, si, sw);
        if (t > 64'sd8388607 || t < -64'sd8388608) govf = 1'b1;
        t = t & 64'hFF_FFFF;
        if (t >= 64'sd8388608) t -= 64'sd16777216;
        gacc = t;
        if (last) begin
            e.psum = ACC_W'(gacc);
            e.ovf  = govf;
            e.due  = cyc + 2;
            exp_q.push_back(e);
            gacc = 0;
            govf = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in       = 8'($urandom);
            bus.weight   = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_last = 1'b0;
    endtask

    task automatic check_val(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every psum_valid pulse must match the oldest queued group.
    always @(negedge clk) begin
        if (rst_n && bus.cfg_err) cfg_seen++;
        if (rst_n && bus.psum_valid) begin
            pulses++;
            obs_psum = bus.psum;
            obs_ovf  = bus.ovf;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_psum observed=%0d expected=none", bus.psum);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (bus.psum === e.psum) else begin
                    errors++;
                    $error("FAIL psum observed=%0d expected=%0d", bus.psum, e.psum);
                end
                checks++;
                assert (bus.ovf === e.ovf) else begin
                    errors++;
                    $error("FAIL ovf observed=%0d expected=%0d", bus.ovf, e.ovf);
                end
                checks++;
                assert (cyc === e.due) else begin
                    errors++;
                    $error("FAIL latency observed_cycle=%0d expected_cycle=%0d", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in = '0; bus.weight = '0;
        bus.in_width = 4'd8; bus.weight_width = 4'd8; bus.s_in = 1'b0; bus.s_weight = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_psum", longint'(bus.psum), 0);
        check_val("reset_psum_valid", longint'(bus.psum_valid), 0);
        check_val("reset_ovf", longint'(bus.ovf), 0);
        check_val("reset_cfg_err", longint'(bus.cfg_err), 0);
        rst_n = 1'b1;
        idle(2);

        beat(8'h80, 8'hFF, 8, 8, 1, 1, 1);
        idle(3);
        check_val("s8x8_psum", longint'(obs_psum), 128);
        check_val("s8x8_ovf", longint'(obs_ovf), 0);

        beat(8'hFF, 8'h1B, 2, 2, 0, 0, 1);
        idle(3);
        check_val("u2x2_psum", longint'(obs_psum), 18);

        beat(8'h7F, 8'h21, 4, 2, 1, 1, 1);
        idle(3);
        check_val("s4x2_psum", longint'(obs_psum), 24'hFFFFF1);

        p0 = pulses;
        beat(255, 255, 8, 8, 0, 0, 0);
        idle(1);
        beat(255, 255, 8, 8, 0, 0, 0);
        beat(255, 255, 8, 8, 0, 0, 1);
        idle(3);
        check_val("accum_psum", longint'(obs_psum), 195075);
        check_val("accum_pulses", longint'(pulses - p0), 1);
        beat(2, 3, 8, 8, 0, 0, 1);
        idle(3);
        check_val("accum_cleared", longint'(obs_psum), 6);

        for (int i = 0; i < 300; i++) beat(255, 255, 8, 8, 0, 0, i == 299);
        idle(3);
        check_val("ovf_psum", longint'(obs_psum), 2730284);
        check_val("ovf_flag", longint'(obs_ovf), 1);
        beat(1, 1, 8, 8, 0, 0, 1);
        idle(3);
        check_val("ovf_cleared", longint'(obs_ovf), 0);

        p0 = pulses;
        beat(7, 9, 8, 8, 0, 0, 1);
        beat(7, 9, 8, 8, 0, 0, 1);
        beat(7, 9, 8, 8, 0, 0, 1);
        idle(3);
        check_val("b2b_pulses", longint'(pulses - p0), 3);

        beat(10, 10, 8, 8, 0, 0, 0);
        beat(10, 10, 8, 8, 0, 0, 0);
        rst_n = 1'b0;
        gacc = 0;
        govf = 1'b0;
        #1;
        check_val("midrst_psum", longint'(bus.psum), 0);
        check_val("midrst_ovf", longint'(bus.ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        beat(5, 5, 8, 8, 0, 0, 1);
        idle(3);
        check_val("midrst_psum_after", longint'(obs_psum), 25);

        beat(8'h5A, 8'h33, 3, 8, 0, 0, 1);
        idle(3);
        check_val("cfg_err_pulses", longint'(cfg_seen), 1);
        check_val("cfg_err_psum", longint'(obs_psum), 0);

        for (int i = 0; i < 10000; i++) begin
            int iw, ww;
            iw = 1 << $urandom_range(0, 3);
            ww = 1 << $urandom_range(0, 3);
            beat(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), iw, ww,
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) || (i == 9999));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(4);
        check_val("queue_drained", longint'(exp_q.size()), 0);
        check_val("cfg_err_total", longint'(cfg_seen), longint'(cfg_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
